// File: rtl/router_fifo.sv
// ---------------------------------------------------------------------------
// router_fifo
//
// Per-destination output FIFO of the 1x3 router. It sits directly downstream
// of the synchronizer, and there is one instance per output port. Every entry
// stores a header flag alongside the data byte. On the read side the flag lets
// the block track packet boundaries and pulse pkt_done on the final (parity)
// byte of each packet.
//
// Parameters:
//   WIDTH  data byte width (stored entry is WIDTH+1 bits); must be >= 8
//   DEPTH  number of entries, power of 2
//   AW     log2(DEPTH)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-low reset
//   soft_reset  synchronous active-high flush (read timeout in synchronizer)
//   write_enb   write request from synchronizer wr_en bit
//   read_enb    read request from destination client
//   lfd_state   high when data_in is a packet header byte
//   data_in     write data
//   data_out    registered read data
//   data_valid  high one cycle after an accepted read
//   pkt_done    one-cycle pulse with data_valid on the last byte of a packet
//   full        FIFO full
//   empty       FIFO empty
//
// Optional feature, enabled by defining ROUTER_FIFO_OCCUPANCY_EN:
//   occupancy        current number of stored entries (0..DEPTH)
//   overflow_sticky  set by any write attempt while full, cleared by either
//                    reset
// ---------------------------------------------------------------------------
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             pkt_done,
  output logic             full,
  output logic             empty
`ifdef ROUTER_FIFO_OCCUPANCY_EN
  ,
  output logic [AW:0]      occupancy,
  output logic             overflow_sticky
`endif
);

  localparam logic [AW:0] PtrOne = 1;

  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [5:0]        pktCnt_q, pktCnt_d;
  logic [WIDTH-1:0]  dataOut_q, dataOut_d;
  logic              dataValid_q, dataValid_d;
  logic              pktDone_q, pktDone_d;

  logic [WIDTH-1:0]  memData [DEPTH];
  logic [DEPTH-1:0]  hdrFlag_q;

  logic              clearAll;
  logic              wrAccept;
  logic              rdAccept;
  logic [WIDTH-1:0]  rdData;
  logic              rdHdr;

  // Both resets clear exactly the same state, so they share one term.
  assign clearAll = !rst || soft_reset;

  // One extra pointer bit distinguishes full from empty when low bits match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign wrAccept = write_enb && !full;
  assign rdAccept = read_enb && !empty;

  assign rdData = memData[rptr_q[AW-1:0]];
  assign rdHdr  = hdrFlag_q[rptr_q[AW-1:0]];

  assign data_out   = dataOut_q;
  assign data_valid = dataValid_q;
  assign pkt_done   = pktDone_q;

  // The header byte carries the payload length in bits [7:2]. Loading
  // length+1 makes the count cover the trailing parity byte, so reaching 1
  // marks the last byte of the packet. A stray non-header byte seen while the
  // count is zero leaves the counter alone.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    pktCnt_d    = pktCnt_q;
    dataOut_d   = dataOut_q;
    dataValid_d = 1'b0;
    pktDone_d   = 1'b0;
    if (wrAccept) begin
      wptr_d = wptr_q + PtrOne;
    end
    if (rdAccept) begin
      rptr_d      = rptr_q + PtrOne;
      dataOut_d   = rdData;
      dataValid_d = 1'b1;
      if (rdHdr) begin
        pktCnt_d = rdData[7:2] + 6'd1;
      end else if (pktCnt_q != 6'd0) begin
        pktCnt_d  = pktCnt_q - 6'd1;
        pktDone_d = (pktCnt_q == 6'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clearAll) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      pktCnt_q    <= '0;
      dataOut_q   <= '0;
      dataValid_q <= 1'b0;
      pktDone_q   <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      pktCnt_q    <= pktCnt_d;
      dataOut_q   <= dataOut_d;
      dataValid_q <= dataValid_d;
      pktDone_q   <= pktDone_d;
    end
  end

  // Header flags are cleared so stale flags can never retrigger packet
  // tracking after a flush. The data bytes themselves need no reset.
  always_ff @(posedge clk) begin
    if (clearAll) begin
      hdrFlag_q <= '0;
    end else if (wrAccept) begin
      hdrFlag_q[wptr_q[AW-1:0]] <= lfd_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!clearAll && wrAccept) begin
      memData[wptr_q[AW-1:0]] <= data_in;
    end
  end

`ifdef ROUTER_FIFO_OCCUPANCY_EN
  logic overflowSticky_q;

  assign occupancy       = wptr_q - rptr_q;
  assign overflow_sticky = overflowSticky_q;

  always_ff @(posedge clk) begin
    if (clearAll) begin
      overflowSticky_q <= 1'b0;
    end else if (write_enb && full) begin
      overflowSticky_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// ---------------------------------------------------------------------------
// tb_router_fifo
//
// Self-checking bench for router_fifo. A queue-based model predicts every
// output each cycle. Directed scenarios pin the model with literal values.
// Honours ROUTER_FIFO_OCCUPANCY_EN when defined.
// ---------------------------------------------------------------------------
module tb_router_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             soft_reset = 1'b0;
  logic             write_enb = 1'b0;
  logic             read_enb = 1'b0;
  logic             lfd_state = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             pkt_done;
  logic             full;
  logic             empty;
`ifdef ROUTER_FIFO_OCCUPANCY_EN
  logic [AW:0]      occupancy;
  logic             overflowSticky;
`endif

  router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .soft_reset(soft_reset),
    .write_enb(write_enb),
    .read_enb(read_enb),
    .lfd_state(lfd_state),
    .data_in(data_in),
    .data_out(data_out),
    .data_valid(data_valid),
    .pkt_done(pkt_done),
    .full(full),
    .empty(empty)
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    ,
    .occupancy(occupancy),
    .overflow_sticky(overflowSticky)
`endif
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;
  bit checkEn = 1'b0;

  // Reference model: a queue of {header, data} entries plus a packet counter.
  logic [8:0]       mq[$];
  logic [WIDTH-1:0] expData = '0;
  logic             expValid = 1'b0;
  logic             expDone = 1'b0;
  logic             expOvf = 1'b0;
  int               mCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    logic [8:0] e;
    bit wasFull;
    bit wasEmpty;
    if (!rst || soft_reset) begin
      mq.delete();
      mCnt     = 0;
      expData  = '0;
      expValid = 1'b0;
      expDone  = 1'b0;
      expOvf   = 1'b0;
    end else begin
      wasFull  = (mq.size() == DEPTH);
      wasEmpty = (mq.size() == 0);
      expValid = 1'b0;
      expDone  = 1'b0;
      if (write_enb && wasFull) expOvf = 1'b1;
      if (read_enb && !wasEmpty) begin
        e        = mq.pop_front();
        expData  = e[7:0];
        expValid = 1'b1;
        if (e[8]) begin
          mCnt = (int'(e[7:2]) + 1) % 64;
        end else if (mCnt > 0) begin
          expDone = (mCnt == 1);
          mCnt--;
        end
      end
      if (write_enb && !wasFull) mq.push_back({lfd_state, data_in});
    end
  endtask

  always @(posedge clk) modelStep();

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("data_out", 32'(data_out), 32'(expData));
      checkOutput("data_valid", 32'(data_valid), 32'(expValid));
      checkOutput("pkt_done", 32'(pkt_done), 32'(expDone));
      checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
      checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
`ifdef ROUTER_FIFO_OCCUPANCY_EN
      checkOutput("occupancy", 32'(occupancy), 32'(mq.size()));
      checkOutput("overflow_sticky", 32'(overflowSticky), 32'(expOvf));
`endif
    end
  end

  task automatic applyStimulus(input logic w, input logic r, input logic lfd,
                               input logic [WIDTH-1:0] d, input logic s);
    write_enb  = w;
    read_enb   = r;
    lfd_state  = lfd;
    data_in    = d;
    soft_reset = s;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [WIDTH-1:0] d, input logic lfd);
    applyStimulus(1'b1, 1'b0, lfd, d, 1'b0);
  endtask

  task automatic rd();
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  logic [WIDTH-1:0] pktBytes [5];
  logic             pktDoneExp [5];

  initial begin
    int next;
    int got;
    int cyc;
    logic w;
    logic r;

    pktBytes   = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h5E};
    pktDoneExp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset with a write request pending: nothing may be stored.
    rst = 1'b0;
    write_enb = 1'b1;
    data_in = 8'hAA;
    @(posedge clk);
    #1;
    checkEn = 1'b1;
    checkOutput("reset_empty", 32'(empty), 32'd1);
    checkOutput("reset_full", 32'(full), 32'd0);
    checkOutput("reset_data_out", 32'(data_out), 32'h00);
    checkOutput("reset_data_valid", 32'(data_valid), 32'd0);
    write_enb = 1'b0;
    rst = 1'b1;
    idle();
    checkOutput("reset_no_write", 32'(empty), 32'd1);

    // Packet of header plus three payload bytes plus parity.
    wr(8'h0C, 1'b1);
    wr(8'hA1, 1'b0);
    wr(8'hA2, 1'b0);
    wr(8'hA3, 1'b0);
    wr(8'h5E, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rd();
      checkOutput("pkt_data", 32'(data_out), 32'(pktBytes[i]));
      checkOutput("pkt_done_lit", 32'(pkt_done), 32'(pktDoneExp[i]));
    end
    idle();

    // Fill to full, then overflow attempt, then drain in order.
    for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
    checkOutput("full_after16", 32'(full), 32'd1);
    wr(8'hFF, 1'b0);
    checkOutput("full_after_drop", 32'(full), 32'd1);
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    checkOutput("ovf_set", 32'(overflowSticky), 32'd1);
    checkOutput("occ_16", 32'(occupancy), 32'd16);
`endif
    for (int i = 0; i < 16; i++) begin
      rd();
      checkOutput("drain_data", 32'(data_out), 32'(i));
    end
    checkOutput("drain_empty", 32'(empty), 32'd1);

    // Soft reset in the middle of a packet.
    wr(8'h0C, 1'b1);
    for (int i = 0; i < 6; i++) wr(8'(8'h10 + i), 1'b0);
    rd();
    checkOutput("soft_hdr", 32'(data_out), 32'h0C);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    checkOutput("soft_empty", 32'(empty), 32'd1);
    checkOutput("soft_valid", 32'(data_valid), 32'd0);
    checkOutput("soft_data_out", 32'(data_out), 32'h00);
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    checkOutput("soft_ovf_clr", 32'(overflowSticky), 32'd0);
`endif
    wr(8'h00, 1'b1);
    wr(8'h77, 1'b0);
    rd();
    checkOutput("len0_hdr_done", 32'(pkt_done), 32'd0);
    rd();
    checkOutput("len0_parity", 32'(data_out), 32'h77);
    checkOutput("len0_done", 32'(pkt_done), 32'd1);

    // Simultaneous read and write at full, then at empty.
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i), 1'b0);
    checkOutput("sim_full", 32'(full), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h99, 1'b0);
    checkOutput("sim_full_cleared", 32'(full), 32'd0);
    checkOutput("sim_full_valid", 32'(data_valid), 32'd1);
    checkOutput("sim_full_data", 32'(data_out), 32'h40);
    for (int i = 1; i < 16; i++) begin
      rd();
      checkOutput("sim_drain", 32'(data_out), 32'(8'h40 + i));
    end
    checkOutput("sim_empty", 32'(empty), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h33, 1'b0);
    checkOutput("sim_empty_written", 32'(empty), 32'd0);
    checkOutput("sim_empty_valid", 32'(data_valid), 32'd0);
    rd();
    checkOutput("sim_empty_data", 32'(data_out), 32'h33);

    // Wrap-around stream with occupancy kept in 1..10.
    next = 0;
    got = 0;
    cyc = 0;
    while (got < 40 && cyc < 2000) begin
      w = (next < 40) && (mq.size() < 10) && (($urandom_range(0, 3) != 0) || mq.size() <= 1);
      r = (mq.size() > 0) && ((mq.size() > 1) || (next == 40) || w) && ($urandom_range(0, 1) == 1);
      applyStimulus(w, r, 1'b0, 8'(next), 1'b0);
      if (w) next++;
      if (data_valid) begin
        checkOutput("wrap_order", 32'(data_out), 32'(got));
        got++;
      end
      cyc++;
    end
    checkOutput("wrap_count", 32'(got), 32'd40);

    // Random traffic with occasional headers, flushes and resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 127) != 0);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 63) == 0));
    end
    rst = 1'b1;
    idle();
    idle();
    checkEn = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
